// File: rtl/logic_slice_pkg.sv
// Shared types and helpers for the LogicSlice capture/playback channels.
package logic_slice_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        PLAY = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int     CH_DEPTH   = 960;
    localparam longint LEVEL_BASE = 64'd200000000;

    // Preamble length in clocks: base >> n, never shorter than one cycle.
    // The capture channel uses the same rule, which is what lets the two
    // ends agree on where the pattern starts.
    function automatic logic [63:0] calc_level(input logic [9:0]  n,
                                               input logic [63:0] base);
        logic [63:0] lvl;
        lvl = base >> n;
        return (lvl == 64'd0) ? 64'd1 : lvl;
    endfunction

endpackage

// File: rtl/pattern_mem.sv
// DEPTH x 1 pattern store: one synchronous write port, one combinational
// read port. A read and a write to the same address in one cycle return
// the old value; the new value is visible from the next cycle on.
module pattern_mem #(
    parameter int DEPTH = 960
) (
    input  logic       clk,
    input  logic       wr_en,
    input  logic [9:0] wr_addr,
    input  logic       wr_data,
    input  logic [9:0] rd_addr,
    output logic       rd_data
);

    localparam logic [10:0] DEPTH_W = 11'(DEPTH);

    // Contents deliberately survive reset so a pattern can be replayed.
    logic [DEPTH-1:0] mem;

    logic wr_ok;
    logic rd_ok;

    assign wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH_W);
    assign rd_ok = {1'b0, rd_addr} < DEPTH_W;

    // Out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_addr] <= wr_data;
    end

    assign rd_data = rd_ok ? mem[rd_addr] : 1'b0;

endmodule

// File: rtl/pattern_channel.sv
// Single-bit pattern playback: idle-level sync preamble of calc_level(n)
// cycles, then `length` points from pattern memory, then a one-cycle done.
// All outputs registered; the registered values always describe the state
// being entered, so `out` lines up with the state register.
module pattern_channel
    import logic_slice_pkg::*;
#(
    parameter int     DEPTH = CH_DEPTH,
    parameter longint BASE  = LEVEL_BASE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [9:0] wr_addr,
    input  logic       wr_data,
    input  logic [9:0] n,
    input  logic [9:0] np,
    input  logic       sel_ch,
    input  logic       idle_lvl,
    input  logic       start,
    input  logic       loop,
    input  logic       abort,
    output logic       out,
    output logic       busy,
    output logic       active,
    output logic       done
);

    localparam logic [10:0] DEPTH_W = 11'(DEPTH);
    localparam logic [63:0] BASE_U  = 64'(BASE);

    state_t      state, state_nx;

    // Run parameters captured at the start edge.
    logic [63:0] lvl_q;
    logic [10:0] len_q;
    logic        idle_q;

    // cnt: preamble cycles already shown minus one; idx: point on `out`.
    logic [63:0] cnt;
    logic [9:0]  idx;

    logic [10:0] np_w;
    logic [10:0] len_d;
    logic        pre_last;
    logic        play_last;
    logic [9:0]  rd_addr;
    logic        rd_data;

    logic        out_d, busy_d, active_d, done_d;

    assign np_w      = {1'b0, np};
    assign len_d     = (sel_ch && (np_w < DEPTH_W)) ? np_w : DEPTH_W;
    assign pre_last  = (cnt == lvl_q - 64'd1);
    assign play_last = ({1'b0, idx} == len_q - 11'd1);

    // Address the point that will be registered onto `out` at the next edge.
    assign rd_addr   = (state == PLAY) ? idx + 10'd1 : 10'd0;

    pattern_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // State register together with the registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            out    <= 1'b0;
            busy   <= 1'b0;
            active <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            out    <= out_d;
            busy   <= busy_d;
            active <= active_d;
            done   <= done_d;
        end
    end

    // Next state; abort overrides everything, start only counts in IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start && !abort) state_nx = PRE;
            PRE: begin
                if (abort)         state_nx = IDLE;
                else if (pre_last) state_nx = (len_q == 11'd0) ? DONE : PLAY;
            end
            PLAY: begin
                if (abort)          state_nx = IDLE;
                else if (play_last) state_nx = DONE;
            end
            DONE: begin
                if (abort)     state_nx = IDLE;
                else if (loop) state_nx = PRE;
                else           state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output values for the state being entered.
    always_comb begin
        out_d    = idle_lvl;
        busy_d   = 1'b0;
        active_d = 1'b0;
        done_d   = 1'b0;
        case (state_nx)
            IDLE: out_d = idle_lvl;
            PRE: begin
                // On the start edge idle_q is not latched yet; use the live pin.
                out_d  = (state == IDLE) ? idle_lvl : idle_q;
                busy_d = 1'b1;
            end
            PLAY: begin
                out_d    = rd_data;
                busy_d   = 1'b1;
                active_d = 1'b1;
            end
            DONE: begin
                out_d  = idle_q;
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: out_d = idle_lvl;
        endcase
    end

    // Run parameters and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q  <= 64'd1;
            len_q  <= 11'd0;
            idle_q <= 1'b0;
            cnt    <= 64'd0;
            idx    <= 10'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (state_nx == PRE) begin
                        lvl_q  <= calc_level(n, BASE_U);
                        len_q  <= len_d;
                        idle_q <= idle_lvl;
                        cnt    <= 64'd0;
                        idx    <= 10'd0;
                    end
                end
                PRE: begin
                    if (state_nx == PRE)       cnt <= cnt + 64'd1;
                    else if (state_nx == PLAY) idx <= 10'd0;
                end
                PLAY: begin
                    if (state_nx == PLAY) idx <= idx + 10'd1;
                end
                DONE: begin
                    if (state_nx == PRE) begin
                        cnt <= 64'd0;
                        idx <= 10'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_channel.sv
// Randomized bench for pattern_channel (BASE=16, DEPTH=8). The reference
// derives each cycle's expected {out,busy,active,done} from the run's
// phase arithmetic: level preamble cycles, length points, one done cycle.
module tb_pattern_channel;

    localparam int DEPTH = 8;
    localparam int BASE  = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [9:0] wr_addr = '0;
    logic       wr_data = 1'b0;
    logic [9:0] n = '0;
    logic [9:0] np = '0;
    logic       sel_ch = 1'b0;
    logic       idle_lvl = 1'b0;
    logic       start = 1'b0;
    logic       loop = 1'b0;
    logic       abort = 1'b0;
    logic       out, busy, active, done;

    int checks = 0;
    int failures = 0;
    bit ref_mem [DEPTH];

    pattern_channel #(.DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .n(n), .np(np), .sel_ch(sel_ch),
        .idle_lvl(idle_lvl), .start(start), .loop(loop), .abort(abort),
        .out(out), .busy(busy), .active(active), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic wr(input int addr, input bit data);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 10'(addr); wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
        if (addr < DEPTH) ref_mem[addr] = data;
    endtask

    // One playback. passes>1 uses loop; abort_at>=0 aborts after that
    // cycle's check; wr_c>=0 flips mem[2] with a write committing on the
    // edge after cycle wr_c; rnd adds random writes, start pulses and
    // input churn during the run.
    task automatic run(input int n_i, input int np_i, input bit sel_i,
                       input bit idl_i, input int passes, input int abort_at,
                       input int wr_c, input bit rnd);
        int lvl, len, plen, total, r, paddr;
        bit pend, pdata;
        logic [7:0] exp;
        lvl = int'(64'(BASE) >> n_i);
        if (lvl == 0) lvl = 1;
        len = sel_i ? ((np_i < DEPTH) ? np_i : DEPTH) : DEPTH;
        plen = lvl + len + 1;
        total = passes * plen;
        pend = 1'b0; paddr = 0; pdata = 1'b0;
        @(negedge clk);
        n = 10'(n_i); np = 10'(np_i); sel_ch = sel_i; idle_lvl = idl_i;
        start = 1'b1; loop = (passes > 1); abort = 1'b0;
        for (int c = 0; c <= total; c++) begin
            @(negedge clk);
            if (c == total) exp = {4'b0, idl_i, 3'b000};
            else begin
                r = c % plen;
                if (r < lvl)            exp = {4'b0, idl_i, 3'b100};
                else if (r < lvl + len) exp = {4'b0, ref_mem[r - lvl], 3'b110};
                else                    exp = {4'b0, idl_i, 3'b101};
            end
            chk("cyc", {4'b0, out, busy, active, done}, exp);
            if (pend && paddr < DEPTH) ref_mem[paddr] = pdata;
            pend = 1'b0;
            wr_en = 1'b0;
            idle_lvl = idl_i;
            if (c == abort_at) begin
                abort = 1'b1; start = 1'b0;
                @(negedge clk);
                chk("abort", {4'b0, out, busy, active, done}, {4'b0, idl_i, 3'b000});
                abort = 1'b0;
                break;
            end
            loop = (c < (passes - 1) * plen);
            start = 1'b0;
            if (c < total - 1 && rnd) begin
                start = ($urandom_range(0, 3) == 0);
                n = 10'($urandom_range(0, 7)); np = 10'($urandom_range(0, 12));
                sel_ch = 1'($urandom_range(0, 1)); idle_lvl = 1'($urandom_range(0, 1));
            end
            if (c < total && (c == wr_c || (rnd && $urandom_range(0, 3) == 0))) begin
                paddr = (c == wr_c) ? 2 : $urandom_range(0, 9);
                pdata = (c == wr_c) ? ~ref_mem[2] : 1'($urandom_range(0, 1));
                wr_en = 1'b1; wr_addr = 10'(paddr); wr_data = pdata; pend = 1'b1;
            end
        end
        start = 1'b0; loop = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        bit pat [8];
        #1;
        chk("rst", {4'b0, out, busy, active, done}, 8'h00);
        #20 rst_n = 1'b1;

        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int a = 0; a < DEPTH; a++) wr(a, pat[a]);
        wr(9, 1'b0);                               // out of range, dropped

        run(2, 4, 1'b1, 1'b0, 1, -1, -1, 1'b0);    // basic
        run(4, 5, 1'b0, 1'b1, 1, -1, -1, 1'b0);    // full depth, level 1
        run(4, 20, 1'b1, 1'b1, 1, -1, -1, 1'b0);   // np clamps to DEPTH
        run(2, 4, 1'b1, 1'b0, 3, -1, -1, 1'b0);    // loop x3
        run(2, 4, 1'b1, 1'b0, 2, 7, -1, 1'b0);     // loop then abort
        run(2, 4, 1'b1, 1'b1, 1, 5, -1, 1'b0);     // abort after 2 points
        run(2, 0, 1'b1, 1'b0, 1, -1, -1, 1'b0);    // preamble only
        run(63, 4, 1'b1, 1'b0, 1, -1, -1, 1'b0);   // level forced to 1
        run(4, 4, 1'b1, 1'b0, 1, -1, 2, 1'b0);     // mem[2] written as played
        run(4, 4, 1'b1, 1'b0, 1, -1, -1, 1'b0);    // new mem[2] now visible

        // abort together with start in IDLE: no run
        @(negedge clk);
        idle_lvl = 1'b1; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        chk("abort_start", {4'b0, out, busy, active, done}, 8'h08);
        start = 1'b0; abort = 1'b0;

        // reset mid-preamble clears outputs asynchronously
        @(negedge clk);
        n = 10'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_busy", {7'b0, busy}, 8'h01);
        rst_n = 1'b0;
        #1;
        chk("async_rst", {4'b0, out, busy, active, done}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        run(1, 8, 1'b1, 1'b0, 1, -1, -1, 1'b0);    // memory kept across reset

        for (int k = 0; k < 25; k++)
            run($urandom_range(0, 6), $urandom_range(0, 12), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(1, 2),
                ($urandom_range(0, 4) == 0) ? $urandom_range(0, 10) : -1, -1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so a stuck run still reports.
    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
